// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch (IF) and data (DM) with DM priority,
// bounded IF starvation and a per-transaction timeout; all outputs registered.
module mem_port_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [1:0]        owner
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [SW-1:0] SL = SW'(STARVE_LIMIT);
  localparam logic [TW-1:0] TL = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;
  state_t state, state_n;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] timer;
  logic busy, grant_dm, grant_if, expire, done;
  always_ff @(posedge clk)
    state <= !reset ? IDLE : state_n;
  always_comb
    state_n = grant_dm ? DM_BUSY :
              grant_if ? IF_BUSY :
              done     ? RESP :
              state == RESP ? IDLE : state;
  always_comb begin
    busy     = state == IF_BUSY || state == DM_BUSY;
    grant_dm = state == IDLE && dm_req && (starve_cnt < SL || !if_req);
    grant_if = state == IDLE && if_req && !grant_dm;
    expire   = busy && timer == TL;
    done     = busy && (mem_ack || expire);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
      timer      <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      owner      <= 2'b00;
      if_valid   <= 1'b0;
      dm_valid   <= 1'b0;
      bus_err    <= 1'b0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      bus_err  <= 1'b0;
      if (grant_dm) begin
        mem_req    <= 1'b1;
        mem_we     <= dm_we;
        mem_addr   <= dm_addr;
        mem_wdata  <= dm_wdata;
        owner      <= 2'b10;
        timer      <= '0;
        starve_cnt <= !if_req ? '0 : starve_cnt == SL ? SL : starve_cnt + 1'b1;
      end else if (grant_if) begin
        mem_req    <= 1'b1;
        mem_we     <= 1'b0;
        mem_addr   <= if_addr;
        owner      <= 2'b01;
        timer      <= '0;
        starve_cnt <= '0;
      end else if (busy) begin
        timer <= timer + 1'b1;
        if (done) begin
          mem_req  <= 1'b0;
          mem_we   <= 1'b0;
          bus_err  <= !mem_ack;
          if_valid <= state == IF_BUSY;
          dm_valid <= state == DM_BUSY;
          // ack beats a simultaneous timeout; a timed-out read returns zero
          if (state == DM_BUSY)
            dm_rdata <= mem_ack ? mem_rdata : '0;
          else
            if_rdata <= !mem_ack ? 32'h0 : mem_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        end
      end else if (state == RESP) begin
        owner <= 2'b00;
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with a response scoreboard for mem_port_arbiter.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [63:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata;
  logic [63:0] dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, bus_err, mem_req, mem_we;
  logic [1:0]  owner;
  typedef struct {logic dm; logic err; logic [63:0] data;} exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  logic [63:0] mon_got;
  int n_checks = 0;
  int n_fail = 0;
  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid), .bus_err(bus_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .owner(owner)
  );
  always #5 clk = ~clk;
  always @(negedge clk)
    if (if_valid === 1'b1 || dm_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got if_valid=%b dm_valid=%b, required no response", if_valid, dm_valid);
      end else begin
        mon_e = exp_q.pop_front();
        mon_got = mon_e.dm ? dm_rdata : {32'h0, if_rdata};
        if (dm_valid !== mon_e.dm || if_valid !== !mon_e.dm || bus_err !== mon_e.err || mon_got !== mon_e.data) begin
          n_fail++;
          $display("FAIL response: got dm_valid=%b if_valid=%b bus_err=%b data=%h, required dm_valid=%b bus_err=%b data=%h",
                   dm_valid, if_valid, bus_err, mon_got, mon_e.dm, mon_e.err, mon_e.data);
        end
      end
    end
  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d pending responses, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset;
    bit ok;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_req, mem_we, owner, if_valid, dm_valid, bus_err} !== 7'b0 || mem_addr !== 64'h0 || dm_rdata !== 64'h0 || if_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got mem_req=%b owner=%b valids=%b%b bus_err=%b addr=%h, required all 0",
               mem_req, owner, if_valid, dm_valid, bus_err, mem_addr);
    end
    reset = 1'b1;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h80;
    wait_mem_req(ok);
    dm_req = 1'b0;
    n_checks++;
    if (!ok || owner !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_pre_grant: got mem_req=%b owner=%b, required 1 and 10", mem_req, owner);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || owner !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_mid_txn: got mem_req=%b owner=%b, required 0 and 00", mem_req, owner);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (mem_req !== 1'b0 || dm_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after: got mem_req=%b dm_valid=%b, required 0 and 0", mem_req, dm_valid);
    end
  endtask
  task automatic test_single_fetch;
    bit ok;
    if_addr = 64'h104; if_req = 1'b1;
    exp_q.push_back('{dm: 1'b0, err: 1'b0, data: 64'hAAAABBBB});
    wait_mem_req(ok);
    if_req = 1'b0;
    n_checks++;
    if (!ok || mem_addr !== 64'h104 || mem_we !== 1'b0 || owner !== 2'b01) begin
      n_fail++;
      $display("FAIL fetch_issue: got req=%b addr=%h we=%b owner=%b, required 1 104 0 01", mem_req, mem_addr, mem_we, owner);
    end
    repeat (2) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'hAAAA_BBBB_1111_2222;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 64'h0;
    n_checks++;
    if (if_valid !== 1'b1 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_latency: got if_valid=%b mem_req=%b, required 1 and 0", if_valid, mem_req);
    end
    @(negedge clk);
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fetch_pulse: got if_valid=%b, required 0", if_valid);
    end
    drain("fetch");
  endtask
  task automatic test_store_load;
    bit ok;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 64'h200; dm_wdata = 64'hDEADBEEF_CAFEF00D;
    exp_q.push_back('{dm: 1'b1, err: 1'b0, data: 64'h0});
    wait_mem_req(ok);
    dm_req = 1'b0; dm_wdata = 64'h0;
    n_checks++;
    if (!ok || mem_we !== 1'b1 || mem_addr !== 64'h200 || mem_wdata !== 64'hDEADBEEF_CAFEF00D || owner !== 2'b10) begin
      n_fail++;
      $display("FAIL store_issue: got we=%b addr=%h wdata=%h owner=%b, required 1 200 deadbeefcafef00d 10", mem_we, mem_addr, mem_wdata, owner);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    drain("store");
    dm_req = 1'b1; dm_we = 1'b0;
    exp_q.push_back('{dm: 1'b1, err: 1'b0, data: 64'hDEADBEEF_CAFEF00D});
    wait_mem_req(ok);
    dm_req = 1'b0;
    n_checks++;
    if (!ok || mem_we !== 1'b0 || mem_addr !== 64'h200) begin
      n_fail++;
      $display("FAIL load_issue: got we=%b addr=%h, required 0 200", mem_we, mem_addr);
    end
    @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 64'h0;
    drain("load");
  endtask
  task automatic test_starvation;
    bit ok;
    logic [1:0] exp_own [10] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic [63:0] rd;
    if_addr = 64'h400; dm_addr = 64'h300; dm_we = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wait_mem_req(ok);
      n_checks++;
      if (!ok || owner !== exp_own[i]) begin
        n_fail++;
        $display("FAIL starve_grant_%0d: got owner=%b, required %b", i, owner, exp_own[i]);
      end
      rd = {32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i)};
      exp_q.push_back('{dm: exp_own[i] == 2'b10, err: 1'b0, data: exp_own[i] == 2'b10 ? rd : {32'h0, rd[31:0]}});
      mem_ack = 1'b1; mem_rdata = rd;
      if (i == 9) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      @(negedge clk);
      mem_ack = 1'b0; mem_rdata = 64'h0;
    end
    drain("starve");
  endtask
  task automatic test_timeout;
    bit ok;
    int n;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h500;
    mem_rdata = 64'h5555_6666_7777_8888;
    exp_q.push_back('{dm: 1'b1, err: 1'b1, data: 64'h0});
    wait_mem_req(ok);
    dm_req = 1'b0;
    n = 0;
    while (dm_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!ok || n != 16 || bus_err !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles bus_err=%b, required 16 and 1", n, bus_err);
    end
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 64'h0;
    n_checks++;
    if (mem_req !== 1'b0 || dm_valid !== 1'b0 || bus_err !== 1'b0 || owner !== 2'b00 || dm_rdata !== 64'h0) begin
      n_fail++;
      $display("FAIL late_ack: got req=%b valid=%b err=%b owner=%b rdata=%h, required all 0", mem_req, dm_valid, bus_err, owner, dm_rdata);
    end
    drain("timeout");
  endtask
  task automatic test_ack_timeout_tie;
    bit ok;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h600;
    exp_q.push_back('{dm: 1'b1, err: 1'b0, data: 64'h0123_4567_89AB_CDEF});
    wait_mem_req(ok);
    dm_req = 1'b0;
    repeat (15) @(negedge clk);
    mem_ack = 1'b1; mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 64'h0;
    n_checks++;
    if (!ok || dm_valid !== 1'b1 || bus_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tie: got dm_valid=%b bus_err=%b, required 1 and 0", dm_valid, bus_err);
    end
    drain("tie");
  endtask
  initial begin
    reset = 1'b0;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    if_addr = 64'h0; dm_addr = 64'h0; dm_wdata = 64'h0; mem_rdata = 64'h0;
    @(negedge clk);
    test_reset;
    test_single_fetch;
    test_store_load;
    test_starvation;
    test_timeout;
    test_ack_timeout_tie;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
